// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// wait-counter width and opcode classification helpers.
package alu_seq_pkg;

    localparam int CNT_W = 4;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_EXEC     = 3'd2,
        S_CAPTURE  = 3'd3,
        S_WRITE_LO = 3'd4,
        S_WRITE_HI = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: op_is_legal = 1'b1;
            default:                                       op_is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_muldiv(input logic [4:0] op);
        case (op)
            OP_MUL, OP_DIV: op_is_muldiv = 1'b1;
            default:        op_is_muldiv = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/operand/result bundle between a requester, the sequencer and the ALU.
interface alu_op_sequencer_if;
    logic        start;
    logic [4:0]  opcode_in;
    logic [31:0] ra_in;
    logic [31:0] rb_in;
    logic [31:0] alu_zhi;
    logic [31:0] alu_zlo;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_ra;
    logic [31:0] alu_rb;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        lo_wr;
    logic        hi_wr;
    logic        busy;
    logic        done;
    logic        illegal;

    modport slave (
        input  start, opcode_in, ra_in, rb_in, alu_zhi, alu_zlo,
        output alu_opcode, alu_ra, alu_rb, z_hi, z_lo, lo_wr, hi_wr, busy, done, illegal
    );

    modport master (
        output start, opcode_in, ra_in, rb_in, alu_zhi, alu_zlo,
        input  alu_opcode, alu_ra, alu_rb, z_hi, z_lo, lo_wr, hi_wr, busy, done, illegal
    );
endinterface

// File: rtl/alu_op_sequencer_wait_counter.sv
// Loadable down-counter timing the EXEC phase; terminal flags the last cycle.
module alu_wait_counter
    import alu_seq_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             terminal
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {CNT_W{1'b0}})) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation: latch operands, wait W cycles, capture the
// result and emit single-cycle LO/HI write strobes and a done pulse.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int SIMPLE_CYCLES = 1
) (
    input  logic               clock,
    input  logic               clear,
    alu_op_sequencer_if.slave  bus
);

    state_e      state_q, state_d;
    logic [4:0]  alu_opcode_q, alu_opcode_d;
    logic [31:0] alu_ra_q, alu_ra_d;
    logic [31:0] alu_rb_q, alu_rb_d;
    logic [31:0] z_hi_q, z_hi_d;
    logic [31:0] z_lo_q, z_lo_d;
    logic        lo_wr_q, lo_wr_d;
    logic        hi_wr_q, hi_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        ill_pend_q, ill_pend_d;

    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_term_s;
    logic             op_legal_s;
    logic             op_muldiv_s;
    logic [CNT_W-1:0] cnt_val_s;

    assign op_legal_s  = op_is_legal(alu_opcode_q);
    assign op_muldiv_s = op_is_muldiv(alu_opcode_q);
    assign cnt_val_s   = op_muldiv_s ? CNT_W'(MULDIV_CYCLES) : CNT_W'(SIMPLE_CYCLES);

    alu_wait_counter u_wait (
        .clock    (clock),
        .clear    (clear),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .terminal (cnt_term_s)
    );

    // Next-state and registered-output logic; strobes are computed from the
    // state being entered so they are flop outputs in that state.
    always_comb begin
        state_d      = state_q;
        alu_opcode_d = alu_opcode_q;
        alu_ra_d     = alu_ra_q;
        alu_rb_d     = alu_rb_q;
        z_hi_d       = z_hi_q;
        z_lo_d       = z_lo_q;
        illegal_d    = illegal_q;
        ill_pend_d   = ill_pend_q;
        lo_wr_d      = 1'b0;
        hi_wr_d      = 1'b0;
        done_d       = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    alu_opcode_d = bus.opcode_in;
                    alu_ra_d     = bus.ra_in;
                    alu_rb_d     = bus.rb_in;
                    illegal_d    = 1'b0;
                    state_d      = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // Illegal ops dwell one extra cycle here so done lands two
                // edges after the accepting edge.
                if (op_legal_s) begin
                    cnt_load_s = 1'b1;
                    state_d    = S_EXEC;
                end else if (!ill_pend_q) begin
                    ill_pend_d = 1'b1;
                end else begin
                    ill_pend_d = 1'b0;
                    illegal_d  = 1'b1;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_EXEC: begin
                cnt_dec_s = 1'b1;
                if (cnt_term_s) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_CAPTURE: begin
                z_lo_d  = bus.alu_zlo;
                z_hi_d  = op_muldiv_s ? bus.alu_zhi : 32'h0000_0000;
                lo_wr_d = 1'b1;
                state_d = S_WRITE_LO;
            end
            S_WRITE_LO: begin
                if (op_muldiv_s) begin
                    hi_wr_d = 1'b1;
                    state_d = S_WRITE_HI;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE_HI: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q      <= S_IDLE;
            alu_opcode_q <= 5'b00000;
            alu_ra_q     <= 32'h0000_0000;
            alu_rb_q     <= 32'h0000_0000;
            z_hi_q       <= 32'h0000_0000;
            z_lo_q       <= 32'h0000_0000;
            lo_wr_q      <= 1'b0;
            hi_wr_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            ill_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_opcode_q <= alu_opcode_d;
            alu_ra_q     <= alu_ra_d;
            alu_rb_q     <= alu_rb_d;
            z_hi_q       <= z_hi_d;
            z_lo_q       <= z_lo_d;
            lo_wr_q      <= lo_wr_d;
            hi_wr_q      <= hi_wr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
            ill_pend_q   <= ill_pend_d;
        end
    end

    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_ra     = alu_ra_q;
    assign bus.alu_rb     = alu_rb_q;
    assign bus.z_hi       = z_hi_q;
    assign bus.z_lo       = z_lo_q;
    assign bus.lo_wr      = lo_wr_q;
    assign bus.hi_wr      = hi_wr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random checks of alu_op_sequencer against a latency/result model.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int MD_W = 4;
    localparam int SM_W = 1;

    logic clock;
    logic clear;
    int   total;
    int   bad;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.MULDIV_CYCLES(MD_W), .SIMPLE_CYCLES(SM_W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference ALU: {hi, lo}. Simple ops put a marker on hi so zeroing is visible.
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'b00011: p = {32'hDEAD_BEEF, a + b};
            5'b00100: p = {32'hDEAD_BEEF, a - b};
            5'b00101: p = {32'hDEAD_BEEF, a >> b[4:0]};
            5'b00110: p = {32'hDEAD_BEEF, a << b[4:0]};
            5'b00111: p = {32'hDEAD_BEEF, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
            5'b01000: p = {32'hDEAD_BEEF, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
            5'b01001: p = {32'hDEAD_BEEF, a & b};
            5'b01010: p = {32'hDEAD_BEEF, a | b};
            5'b01110: p = 64'(sa * sb);
            5'b01111: p = (b == 32'd0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
            5'b10000: p = {32'hDEAD_BEEF, 32'd0 - a};
            5'b10001: p = {32'hDEAD_BEEF, ~a};
            default:  p = 64'h1234_5678_9ABC_DEF0;
        endcase
        return p;
    endfunction

    assign {bus.alu_zhi, bus.alu_zlo} = ref_alu(bus.alu_opcode, bus.alu_ra, bus.alu_rb);

    function automatic bit legal_op(input logic [4:0] op);
        logic [4:0] legal_list [12];
        legal_list = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17};
        foreach (legal_list[i]) if (legal_list[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_lo_wr"}, 64'(bus.lo_wr), 64'd0);
        check({tag, "_hi_wr"}, 64'(bus.hi_wr), 64'd0);
        check({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
        check({tag, "_z"}, {bus.z_hi, bus.z_lo}, 64'd0);
        check({tag, "_alu_op"}, {27'd0, bus.alu_opcode, bus.alu_ra}, 64'd0);
        check({tag, "_alu_rb"}, 64'(bus.alu_rb), 64'd0);
    endtask

    task automatic garbage_inputs();
        bus.opcode_in = 5'($urandom);
        bus.ra_in     = $urandom;
        bus.rb_in     = $urandom;
    endtask

    // Called at a negedge; start is accepted at the next rising edge (edge k).
    // poke_at>0 pulses start with an Add across edge k+poke_at.
    task automatic do_op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b, input int poke_at);
        bit legal, md;
        int lat, lo_at, hi_at;
        logic [63:0] r;
        logic [31:0] exp_hi, exp_lo;
        legal = legal_op(opc);
        md    = legal && (opc == 5'b01110 || opc == 5'b01111);
        lat   = !legal ? 2 : (md ? 4 + MD_W : 3 + SM_W);
        lo_at = !legal ? -1 : (md ? lat - 2 : lat - 1);
        hi_at = md ? lat - 1 : -1;
        r = ref_alu(opc, a, b);
        exp_lo = legal ? r[31:0] : prev_lo;
        exp_hi = legal ? (md ? r[63:32] : 32'd0) : prev_hi;
        bus.start = 1'b1;
        bus.opcode_in = opc;
        bus.ra_in = a;
        bus.rb_in = b;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        garbage_inputs();
        for (int n = 1; n <= lat + 1; n++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("done_op%0h_n%0d", opc, n), 64'(bus.done), 64'(n == lat));
            check($sformatf("lo_wr_op%0h_n%0d", opc, n), 64'(bus.lo_wr), 64'(n == lo_at));
            check($sformatf("hi_wr_op%0h_n%0d", opc, n), 64'(bus.hi_wr), 64'(n == hi_at));
            check($sformatf("busy_op%0h_n%0d", opc, n), 64'(bus.busy), 64'(n <= lat));
            if (n == lat) begin
                check($sformatf("illegal_op%0h", opc), 64'(bus.illegal), 64'(!legal));
                check($sformatf("z_lo_op%0h", opc), 64'(bus.z_lo), 64'(exp_lo));
                check($sformatf("z_hi_op%0h", opc), 64'(bus.z_hi), 64'(exp_hi));
                check($sformatf("alu_regs_op%0h", opc), {27'd0, bus.alu_opcode, bus.alu_ra}, {27'd0, opc, a});
                check($sformatf("alu_rb_op%0h", opc), 64'(bus.alu_rb), 64'(b));
            end
            if (n + 1 == poke_at) begin
                bus.start = 1'b1;
                bus.opcode_in = OP_ADD;
                bus.ra_in = 32'd1;
                bus.rb_in = 32'd1;
            end else begin
                bus.start = 1'b0;
                garbage_inputs();
            end
        end
        prev_lo = exp_lo;
        prev_hi = exp_hi;
    endtask

    initial begin
        logic [4:0]  ro;
        logic [31:0] ra, rb;
        total = 0;
        bad = 0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        clear = 1'b0;
        bus.start = 1'b0;
        bus.opcode_in = 5'd0;
        bus.ra_in = 32'd0;
        bus.rb_in = 32'd0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        clear = 1'b1;

        do_op(OP_ADD, 32'd5, 32'd7, 0);
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(5'b11111, 32'd3, 32'd4, 0);
        do_op(OP_DIV, 32'd100, 32'd7, 3);
        // The ignored Add pulse must not start anything afterwards.
        @(negedge clock);
        check("no_queued_start", 64'(bus.busy), 64'd0);

        // Asynchronous clear during EXEC of a Mul.
        bus.start = 1'b1;
        bus.opcode_in = OP_MUL;
        bus.ra_in = 32'd123;
        bus.rb_in = 32'd456;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check_zero("mid_clear");
        @(negedge clock);
        check_zero("held_clear");
        clear = 1'b1;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        do_op(OP_SUB, 32'd9, 32'd4, 0);

        for (int i = 0; i < 25; i++) begin
            ro = 5'($urandom);
            if (($urandom % 3) != 0) begin
                case ($urandom % 4)
                    0: ro = OP_MUL;
                    1: ro = OP_DIV;
                    2: ro = OP_ROR;
                    default: ro = 5'(3 + ($urandom % 8));
                endcase
            end
            ra = $urandom;
            rb = $urandom | 32'd1;
            do_op(ro, ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter MULDIV_CYCLES, default 4, EXEC hold cycles for Multiply/Divide (range 1..15).
REQ-002 The block SHALL have parameter SIMPLE_CYCLES, default 1, EXEC hold cycles for all other legal opcodes (range 1..15).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 clear  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 opcode_in  in  5  requested operation.
REQ-008 ra_in, rb_in  in  32 each  operand values, sampled with start.
REQ-009 alu_zhi, alu_zlo  in  32 each  combinational ALU results.
REQ-010 alu_opcode  out  5  registered opcode driven to ALU.
REQ-011 alu_ra, alu_rb  out  32 each  registered operands driven to ALU.
REQ-012 z_hi, z_lo  out  32 each  captured result registers.
REQ-013 lo_wr, hi_wr  out  1 each  single-cycle LO/HI write strobes.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  single-cycle completion pulse.
REQ-016 illegal  out  1  set with done when opcode was not legal; held until next start accepted.

Function
REQ-017 Legal opcodes SHALL be Add 00011, Sub 00100, Shr 00101, Shl 00110, Ror 00111, Rol 01000, And 01001, Or 01010, Mul 01110, Div 01111, Neg 10000, Not 10001; all others illegal.
REQ-018 FSM states SHALL be IDLE, LOAD, EXEC, CAPTURE, WRITE_LO, WRITE_HI, DONE.
REQ-019 IDLE: start=1 at edge k SHALL register opcode_in, ra_in, rb_in into alu_opcode/alu_ra/alu_rb, clear illegal, go to LOAD.
REQ-020 LOAD: legal opcode -> EXEC with wait counter loaded to MULDIV_CYCLES (Mul/Div) or SIMPLE_CYCLES; illegal -> DONE with illegal=1.
REQ-021 EXEC: counter decrements each cycle; -> CAPTURE on the edge where counter reaches 1 (exactly W cycles in EXEC).
REQ-022 CAPTURE: z_lo<=alu_zlo; z_hi<=alu_zhi for Mul/Div, z_hi<=0 otherwise; -> WRITE_LO.
REQ-023 WRITE_LO: lo_wr=1 for this cycle only; -> WRITE_HI for Mul/Div, else DONE.
REQ-024 WRITE_HI: hi_wr=1 for this cycle only; -> DONE.
REQ-025 DONE: done=1 for this cycle only; -> IDLE unconditionally.
REQ-026 Latency: done SHALL be high after edge k+3+W for non-Mul/Div, k+4+W for Mul/Div, k+2 for illegal.
REQ-027 start while busy=1 SHALL be ignored and not queued; opcode_in/ra_in/rb_in changes while busy SHALL not affect outputs.
REQ-028 alu_opcode/alu_ra/alu_rb SHALL remain stable from LOAD through DONE and hold after return to IDLE.
REQ-029 z_hi/z_lo SHALL hold last captured values until next CAPTURE; illegal ops SHALL not modify them.
REQ-030 lo_wr, hi_wr, done SHALL never be high in the same cycle.

Reset
REQ-031 clear=0 SHALL asynchronously force IDLE and zero every output, counter and register, including mid-operation.
REQ-032 The first start SHALL be accepted on the first rising edge with clear=1.

Structure
REQ-033 Shared package alu_seq_pkg SHALL hold the opcode constants, state enumeration and counter width.
REQ-034 One sub-module, alu_wait_counter (load/decrement/terminal flag), SHALL implement the EXEC counter.

Verification
REQ-035 Add, ra=5, rb=7, ALU model -> lo_wr at k+3, z_lo=12, z_hi=0, done at k+4, hi_wr never asserted.
REQ-036 Mul, ra=0xFFFFFFFF, rb=2 -> z_hi=0xFFFFFFFF, z_lo=0xFFFFFFFE, lo_wr at k+6, hi_wr at k+7, done at k+8.
REQ-037 opcode 11111 -> done and illegal at k+2, no lo_wr/hi_wr, z_hi/z_lo unchanged from prior op.
REQ-038 Div 100/7 running, start pulsed with Add at k+3 -> ignored; Div completes, z_lo=14, z_hi=2, busy low only after done.
REQ-039 clear=0 asserted during EXEC of Mul -> outputs zero immediately, state IDLE, next Sub 9-4 completes with z_lo=5.
